vga_image_mux: RTL and testbench

//   Parametrised VGA timing generator and image compositor, successor to the single-mode driver.

---
 rtl/vga_image_mux.sv | 191 +++++++++++++++++++
 tb/tb_vga_image_mux.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_image_mux.sv
// VGA timing generator and image compositor: draws one of NUM_IMG ROM images inside a
// bordered window. The image choice is latched at frame end, so a frame never mixes images.
module vga_image_mux #(
    parameter int          H_ACTIVE   = 640,
    parameter int          H_FP       = 16,
    parameter int          H_SYNC     = 96,
    parameter int          H_BP       = 48,
    parameter int          V_ACTIVE   = 480,
    parameter int          V_FP       = 10,
    parameter int          V_SYNC     = 2,
    parameter int          V_BP       = 33,
    parameter int          IMG_W      = 300,
    parameter int          IMG_H      = 200,
    parameter int          IMG_X      = 170,
    parameter int          IMG_Y      = 140,
    parameter int          BORDER     = 8,
    parameter int          NUM_IMG    = 3,
    parameter int          SEL_W      = 2,
    parameter int          ADDR_W     = 18,
    parameter logic [11:0] BORDER_RGB = 12'h0F0,
    parameter logic [11:0] BG_RGB     = 12'hFFF
) (
    input  logic              vga_clk,
    input  logic              rst_n,
    input  logic [SEL_W-1:0]  sel,
    output logic              hsync,
    output logic              vsync,
    output logic              de,
    output logic [3:0]        red,
    output logic [3:0]        green,
    output logic [3:0]        blue,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_en,
    input  logic [11:0]       rom_data,
    output logic              frame_start
);

    function automatic int min_i(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    localparam int H_TOT  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW     = $clog2(H_TOT + 1);
    localparam int VW     = $clog2(V_TOT + 1);
    localparam int IMG_SZ = IMG_W * IMG_H;

    localparam logic [HW-1:0] H_LAST    = HW'(H_TOT - 1);
    localparam logic [VW-1:0] V_LAST    = VW'(V_TOT - 1);
    localparam logic [HW-1:0] H_ACT     = HW'(H_ACTIVE);
    localparam logic [VW-1:0] V_ACT     = VW'(V_ACTIVE);
    localparam logic [HW-1:0] H_SYNC_LO = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SYNC_HI = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_SYNC_LO = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SYNC_HI = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [HW-1:0] H_WIN_LO  = HW'(min_i(IMG_X, H_TOT));
    localparam logic [HW-1:0] H_WIN_HI  = HW'(min_i(IMG_X + IMG_W, H_TOT));
    localparam logic [VW-1:0] V_WIN_LO  = VW'(min_i(IMG_Y, V_TOT));
    localparam logic [VW-1:0] V_WIN_HI  = VW'(min_i(IMG_Y + IMG_H, V_TOT));
    localparam logic [HW-1:0] H_BRD_LO  = HW'((IMG_X > BORDER) ? IMG_X - BORDER : 0);
    localparam logic [HW-1:0] H_BRD_HI  = HW'(min_i(IMG_X + IMG_W + BORDER, H_TOT));
    localparam logic [VW-1:0] V_BRD_LO  = VW'((IMG_Y > BORDER) ? IMG_Y - BORDER : 0);
    localparam logic [VW-1:0] V_BRD_HI  = VW'(min_i(IMG_Y + IMG_H + BORDER, V_TOT));

    logic [HW-1:0]     h_r;
    logic [VW-1:0]     v_r;
    logic [ADDR_W-1:0] offset_r;
    logic [SEL_W-1:0]  cur_sel_r;
    logic              active_s, win_s, border_s, hs_s, vs_s, valid_s, frame_end_s;
    logic [ADDR_W-1:0] base_s;
    logic [11:0]       col_s;
    logic              hs_r1, vs_r1, de_r1;
    logic [11:0]       col_r1;
    logic              img_r2;
    logic [11:0]       col_r2;
    logic [11:0]       pix_s;

    // Pixel and line counters.
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            h_r <= '0;
            v_r <= '0;
        end else if (h_r == H_LAST) begin
            h_r <= '0;
            if (v_r == V_LAST) begin
                v_r <= '0;
            end else begin
                v_r <= v_r + VW'(1);
            end
        end else begin
            h_r <= h_r + HW'(1);
        end
    end

    // Region decode for the current counter position.
    always_comb begin
        active_s    = (h_r < H_ACT) && (v_r < V_ACT);
        win_s       = active_s && (h_r >= H_WIN_LO) && (h_r < H_WIN_HI)
                                && (v_r >= V_WIN_LO) && (v_r < V_WIN_HI);
        border_s    = active_s && !win_s && (h_r >= H_BRD_LO) && (h_r < H_BRD_HI)
                                && (v_r >= V_BRD_LO) && (v_r < V_BRD_HI);
        hs_s        = !((h_r >= H_SYNC_LO) && (h_r < H_SYNC_HI));
        vs_s        = !((v_r >= V_SYNC_LO) && (v_r < V_SYNC_HI));
        frame_end_s = (h_r == H_LAST) && (v_r == V_LAST);
        // Widened compare so NUM_IMG == 2**SEL_W still works.
        valid_s     = ({1'b0, cur_sel_r} < (SEL_W + 1)'(NUM_IMG));
        base_s      = ADDR_W'(cur_sel_r) * ADDR_W'(IMG_SZ);
    end

    // Fixed colour for non-image pixels, resolved by priority.
    always_comb begin
        col_s = 12'h000;
        if (!active_s) begin
            col_s = 12'h000;
        end else if (win_s) begin
            col_s = BG_RGB;
        end else if (border_s) begin
            col_s = BORDER_RGB;
        end else begin
            col_s = BG_RGB;
        end
    end

    // Per-frame image select and window pixel offset; both restart at the frame boundary.
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            offset_r  <= '0;
            cur_sel_r <= '0;
        end else if (frame_end_s) begin
            offset_r  <= '0;
            cur_sel_r <= sel;
        end else if (win_s) begin
            offset_r  <= offset_r + ADDR_W'(1);
        end else begin
            offset_r  <= offset_r;
        end
    end

    // Stage 1: ROM request plus delayed timing and colour control.
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_addr    <= '0;
            rom_en      <= 1'b0;
            frame_start <= 1'b0;
            hs_r1       <= 1'b1;
            vs_r1       <= 1'b1;
            de_r1       <= 1'b0;
            col_r1      <= 12'h000;
        end else begin
            rom_addr    <= base_s + offset_r;
            rom_en      <= win_s && valid_s;
            frame_start <= (h_r == HW'(0)) && (v_r == VW'(0));
            hs_r1       <= hs_s;
            vs_r1       <= vs_s;
            de_r1       <= active_s;
            col_r1      <= col_s;
        end
    end

    // Stage 2: sync and pixel-source select, aligned with ROM read data.
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync  <= 1'b1;
            vsync  <= 1'b1;
            de     <= 1'b0;
            img_r2 <= 1'b0;
            col_r2 <= 12'h000;
        end else begin
            hsync  <= hs_r1;
            vsync  <= vs_r1;
            de     <= de_r1;
            img_r2 <= rom_en;
            col_r2 <= col_r1;
        end
    end

    // ROM data arrives in this cycle, so the final colour select is combinational.
    always_comb begin
        pix_s = 12'h000;
        if (img_r2) begin
            pix_s = rom_data;
        end else begin
            pix_s = col_r2;
        end
    end

    assign red   = pix_s[11:8];
    assign green = pix_s[7:4];
    assign blue  = pix_s[3:0];

endmodule

// File: tb/tb_vga_image_mux.sv
// Self-checking bench for vga_image_mux with reduced timing so several frames fit in a short run.
`timescale 1ns/1ps
module tb_vga_image_mux;

    localparam int HA = 40, HFP = 4, HS = 6, HBP = 6;
    localparam int VA = 30, VFP = 2, VS = 2, VBP = 3;
    localparam int IW = 10, IH = 8, IX = 24, IY = 25, BRD = 2;
    localparam int NIMG = 3, SW = 2, AW = 10;
    localparam int H_TOT = HA + HFP + HS + HBP;
    localparam int V_TOT = VA + VFP + VS + VBP;
    localparam int FRAME = H_TOT * V_TOT;
    localparam int VISW  = ((IX + IW) < HA ? (IX + IW) : HA) - IX;
    localparam int VISH  = ((IY + IH) < VA ? (IY + IH) : VA) - IY;
    localparam logic [11:0] C_BRD = 12'h0F0;
    localparam logic [11:0] C_BG  = 12'hFFF;

    typedef struct packed {
        logic          en;
        logic [AW-1:0] addr;
        logic          fs;
        logic          hs;
        logic          vs;
        logic          de;
        logic [11:0]   col;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [SW-1:0] sel;
    logic          hsync, vsync, de, rom_en, frame_start;
    logic [3:0]    red, green, blue;
    logic [AW-1:0] rom_addr;
    logic [11:0]   rom_data = 12'h000;

    int   checks = 0;
    int   errors = 0;
    int   t, cs, en_cnt, fs_cnt;
    bit   have1, have2;
    exp_t e1, e2;

    vga_image_mux #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .IMG_W(IW), .IMG_H(IH), .IMG_X(IX), .IMG_Y(IY), .BORDER(BRD),
        .NUM_IMG(NIMG), .SEL_W(SW), .ADDR_W(AW),
        .BORDER_RGB(C_BRD), .BG_RGB(C_BG)
    ) dut (
        .vga_clk(clk), .rst_n(rst_n), .sel(sel),
        .hsync(hsync), .vsync(vsync), .de(de),
        .red(red), .green(green), .blue(blue),
        .rom_addr(rom_addr), .rom_en(rom_en), .rom_data(rom_data),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // Synchronous ROM whose content at each address is the address itself.
    always @(posedge clk) rom_data <= {2'b00, rom_addr};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        assert (got === expv) else begin
            errors++;
            $error("FAIL %s t=%0d: observed %0h expected %0h", tag, t, got, expv);
        end
    endtask

    // Expected behaviour for counter position t of a frame showing image cs.
    function automatic exp_t model(input int tt, input int csel);
        exp_t e;
        int h, v;
        bit act, win, brd, ok;
        h   = tt % H_TOT;
        v   = (tt / H_TOT) % V_TOT;
        act = (h < HA) && (v < VA);
        win = act && (h >= IX) && (h < IX + IW) && (v >= IY) && (v < IY + IH);
        brd = act && !win && (h >= IX - BRD) && (h < IX + IW + BRD)
                          && (v >= IY - BRD) && (v < IY + IH + BRD);
        ok  = (csel < NIMG);
        e.fs   = (h == 0) && (v == 0);
        e.hs   = !((h >= HA + HFP) && (h < HA + HFP + HS));
        e.vs   = !((v >= VA + VFP) && (v < VA + VFP + VS));
        e.de   = act;
        e.en   = win && ok;
        e.addr = win ? AW'(csel * IW * IH + (v - IY) * VISW + (h - IX)) : '0;
        e.col  = !act ? 12'h000 : (win ? C_BG : (brd ? C_BRD : C_BG));
        return e;
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_hsync"}, 32'(hsync), 32'd1);
        chk({tag, "_vsync"}, 32'(vsync), 32'd1);
        chk({tag, "_de"}, 32'(de), 32'd0);
        chk({tag, "_rgb"}, 32'({red, green, blue}), 32'd0);
        chk({tag, "_rom_en"}, 32'(rom_en), 32'd0);
        chk({tag, "_rom_addr"}, 32'(rom_addr), 32'd0);
        chk({tag, "_fs"}, 32'(frame_start), 32'd0);
    endtask

    task automatic model_release();
        t = -1; cs = 0; have1 = 1'b0; have2 = 1'b0; en_cnt = 0; fs_cnt = 0;
    endtask

    // Advance the model one cycle and compare both pipeline stages.
    task automatic tick(input bit wait_edge);
        if (wait_edge) @(negedge clk);
        #1;
        t++;
        en_cnt += int'(rom_en);
        fs_cnt += int'(frame_start);
        if ((t % FRAME) == 0 && t > 0) begin
            chk("en_per_frame", 32'(en_cnt), (cs < NIMG) ? 32'(VISW * VISH) : 32'd0);
            en_cnt = 0;
            cs = int'(sel);
        end
        if (have1) begin
            chk("rom_en", 32'(rom_en), 32'(e1.en));
            chk("frame_start", 32'(frame_start), 32'(e1.fs));
            if (e1.en) chk("rom_addr", 32'(rom_addr), 32'(e1.addr));
        end else begin
            chk("rom_en_rst", 32'(rom_en), 32'd0);
            chk("fs_rst", 32'(frame_start), 32'd0);
        end
        if (have2) begin
            chk("hsync", 32'(hsync), 32'(e2.hs));
            chk("vsync", 32'(vsync), 32'(e2.vs));
            chk("de", 32'(de), 32'(e2.de));
            chk("rgb", 32'({red, green, blue}), e2.en ? 32'(12'(e2.addr)) : 32'(e2.col));
        end else begin
            chk("sync_rst", 32'({hsync, vsync, de}), 32'b110);
        end
        e2 = e1; have2 = have1;
        e1 = model(t, cs); have1 = 1'b1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick(1'b1);
    endtask

    task automatic run_to(input int hh, input int vv);
        int guard = 0;
        while (!(((t + 1) % H_TOT) == hh && (((t + 1) / H_TOT) % V_TOT) == vv) && guard < 2 * FRAME) begin
            tick(1'b1);
            guard++;
        end
        chk("run_to_bound", 32'(guard < 2 * FRAME), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        sel   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("por");
        rst_n = 1'b1;
        model_release();
        tick(1'b0);

        // Two frames of image 0.
        run(2 * FRAME);

        // Select image 1 mid-frame; takes effect next frame.
        sel = 2'd1;
        run(FRAME + 100);

        // Switch to image 2 mid-frame at line 20.
        run_to(0, 20);
        sel = 2'd2;
        run(FRAME);

        // Invalid select: background in window, border still drawn.
        sel = 2'd3;
        run(2 * FRAME);

        // Random selections changed at arbitrary points.
        for (int k = 0; k < 6; k++) begin
            sel = SW'($urandom_range(0, 3));
            run(int'($urandom_range(300, 1500)));
        end

        // Mid-frame asynchronous reset.
        run_to(20, 15);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        repeat (3) @(posedge clk);
        @(negedge clk);
        sel   = 2'd1;
        rst_n = 1'b1;
        model_release();
        tick(1'b0);
        run(2 * FRAME + 1);
        chk("fs_count_after_reset", 32'(fs_cnt), 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
